// File: rtl/silife_sched_pkg.sv
// Shared definitions for the SiLife generation scheduler: register map,
// CTRL bit positions and scheduler state encoding.
package silife_sched_pkg;

    localparam logic [23:0] ADDR_CTRL      = 24'h000000;
    localparam logic [23:0] ADDR_PERIOD    = 24'h000001;
    localparam logic [23:0] ADDR_GEN_LIMIT = 24'h000002;

    localparam int CTRL_RUN_BIT     = 0;
    localparam int CTRL_STEP_BIT    = 1;
    localparam int CTRL_CLR_GEN_BIT = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT     = 2'd1,
        HOLD     = 2'd2,
        STEP_REQ = 2'd3
    } sched_state_t;

endpackage

// File: rtl/silife_step_timer.sv
// Loadable step-period down-counter; a load value of 0 is treated as 1.
module silife_step_timer #(
    parameter int PERIOD_BITS = 24
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_load,
    input  logic [PERIOD_BITS-1:0] i_load_value,
    input  logic                   i_enable,
    output logic                   o_zero
);

    logic [PERIOD_BITS-1:0] r_count;
    logic [PERIOD_BITS-1:0] w_load_value;

    assign w_load_value = (i_load_value == '0) ? PERIOD_BITS'(1) : i_load_value;

    // Flags the cycle whose decrement lands on zero, so a load of P yields P enabled cycles.
    assign o_zero = (r_count <= PERIOD_BITS'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= w_load_value;
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - PERIOD_BITS'(1);
        end
    end

endmodule

// File: rtl/silife_step_scheduler.sv
// SiLife generation scheduler: control-register decode, step FSM and generation counter.
// Optional GEN_LIMIT auto-stop is built when SILIFE_GEN_LIMIT_EN is defined.
module silife_step_scheduler
    import silife_sched_pkg::*;
#(
    parameter int                     PERIOD_BITS  = 24,
    parameter int                     GEN_BITS     = 32,
    parameter logic [PERIOD_BITS-1:0] RESET_PERIOD = PERIOD_BITS'(24'd1000000)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_control_write,
    input  logic [23:0]         i_control_addr,
    input  logic [31:0]         i_control_data,
    input  logic                i_loader_busy,
    input  logic                i_step_done,
    output logic                o_step_req,
    output logic                o_running,
    output logic [GEN_BITS-1:0] o_generation,
    output logic                o_limit_hit
);

    sched_state_t           r_state;
    sched_state_t           w_state_next;
    logic                   r_step_req;
    logic                   r_run;
    logic                   r_step_armed;
    logic [PERIOD_BITS-1:0] r_period;
    logic [GEN_BITS-1:0]    r_generation;

    logic                   w_wr_ctrl;
    logic                   w_wr_period;
    logic                   w_clr_gen;
    logic                   w_step_accept;
    logic                   w_complete;
    logic                   w_limit_match;
    logic                   w_timer_load;
    logic                   w_timer_en;
    logic                   w_timer_zero;
    logic [GEN_BITS-1:0]    w_gen_inc;

    assign w_wr_ctrl   = i_control_write && (i_control_addr == ADDR_CTRL);
    assign w_wr_period = i_control_write && (i_control_addr == ADDR_PERIOD);
    assign w_clr_gen   = w_wr_ctrl && i_control_data[CTRL_CLR_GEN_BIT];
    assign w_complete  = (r_state == STEP_REQ) && i_step_done;
    assign w_gen_inc   = r_generation + GEN_BITS'(1);

    // The armed flag stays set until its step completes, so it also covers "in flight".
    assign w_step_accept = w_wr_ctrl && i_control_data[CTRL_STEP_BIT]
                         && !i_control_data[CTRL_RUN_BIT] && !r_run && !r_step_armed;

`ifdef SILIFE_GEN_LIMIT_EN
    logic                r_gen_limit_hit;
    logic [GEN_BITS-1:0] r_gen_limit;
    logic                w_wr_gen_limit;

    assign w_wr_gen_limit = i_control_write && (i_control_addr == ADDR_GEN_LIMIT);
    assign w_limit_match  = w_complete && !w_clr_gen && (r_gen_limit != '0)
                          && (w_gen_inc == r_gen_limit);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_gen_limit     <= '0;
            r_gen_limit_hit <= 1'b0;
        end else begin
            if (w_wr_gen_limit) begin
                r_gen_limit <= GEN_BITS'(i_control_data);
            end
            r_gen_limit_hit <= w_limit_match;
        end
    end

    assign o_limit_hit = r_gen_limit_hit;
`else
    assign w_limit_match = 1'b0;
    assign o_limit_hit   = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run        <= 1'b0;
            r_period     <= RESET_PERIOD;
            r_step_armed <= 1'b0;
            r_generation <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_run <= i_control_data[CTRL_RUN_BIT];
            end
            if (w_limit_match) begin
                r_run <= 1'b0;
            end
            if (w_wr_period) begin
                r_period <= PERIOD_BITS'(i_control_data);
            end
            if (w_complete) begin
                r_step_armed <= 1'b0;
            end else if (w_step_accept) begin
                r_step_armed <= 1'b1;
            end
            if (w_clr_gen) begin
                r_generation <= '0;
            end else if (w_complete) begin
                r_generation <= w_gen_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_step_req <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_step_req <= (w_state_next == STEP_REQ);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (r_run) begin
                    w_state_next = WAIT;
                end else if (r_step_armed) begin
                    w_state_next = i_loader_busy ? HOLD : STEP_REQ;
                end
            end
            WAIT: begin
                if (!r_run) begin
                    w_state_next = IDLE;
                end else if (w_timer_zero) begin
                    w_state_next = i_loader_busy ? HOLD : STEP_REQ;
                end
            end
            HOLD: begin
                if (!i_loader_busy) begin
                    w_state_next = STEP_REQ;
                end
            end
            STEP_REQ: begin
                if (w_complete) begin
                    w_state_next = (r_run && !w_limit_match) ? WAIT : IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // The timer reloads on every entry into WAIT, which picks up any PERIOD change.
    always_comb begin
        w_timer_load = (w_state_next == WAIT) && (r_state != WAIT);
        w_timer_en   = (r_state == WAIT);
    end

    silife_step_timer #(
        .PERIOD_BITS(PERIOD_BITS)
    ) u_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_load      (w_timer_load),
        .i_load_value(r_period),
        .i_enable    (w_timer_en),
        .o_zero      (w_timer_zero)
    );

    assign o_step_req   = r_step_req;
    assign o_running    = r_run;
    assign o_generation = r_generation;

endmodule

// File: tb/tb_silife_step_scheduler.sv
// Directed testbench for silife_step_scheduler (GEN_BITS=4 to exercise wrap).
module tb_silife_step_scheduler;
    import silife_sched_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        i_control_write;
    logic [23:0] i_control_addr;
    logic [31:0] i_control_data;
    logic        i_loader_busy;
    logic        i_step_done;
    logic        o_step_req;
    logic        o_running;
    logic [3:0]  o_generation;
    logic        o_limit_hit;

    int n_pass  = 0;
    int n_total = 0;

    silife_step_scheduler #(
        .PERIOD_BITS(24),
        .GEN_BITS   (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_control_write(i_control_write),
        .i_control_addr (i_control_addr),
        .i_control_data (i_control_data),
        .i_loader_busy  (i_loader_busy),
        .i_step_done    (i_step_done),
        .o_step_req     (o_step_req),
        .o_running      (o_running),
        .o_generation   (o_generation),
        .o_limit_hit    (o_limit_hit)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [23:0] addr, input logic [31:0] data);
        i_control_write = 1'b1;
        i_control_addr  = addr;
        i_control_data  = data;
        tick;
        i_control_write = 1'b0;
        i_control_addr  = '0;
        i_control_data  = '0;
    endtask

    task automatic wait_req(output int n);
        n = 0;
        do begin
            tick;
            n++;
        end while (!o_step_req && n < 40);
    endtask

    initial begin
        int n;
        int hi;
        int pulses;

        reset_n         = 1'b0;
        i_control_write = 1'b0;
        i_control_addr  = '0;
        i_control_data  = '0;
        i_loader_busy   = 1'b0;
        i_step_done     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_step_req", 32'(o_step_req), 0);
        chk("rst_running", 32'(o_running), 0);
        chk("rst_generation", 32'(o_generation), 0);
        chk("rst_limit_hit", 32'(o_limit_hit), 0);
        chk("rst_state", 32'(dut.r_state), 32'(IDLE));
        chk("rst_period", 32'(dut.r_period), 1000000);
        reset_n = 1'b1;
        tick;

        // Free-running with PERIOD=4 and done held high: requests every 5 clocks.
        wr(ADDR_PERIOD, 32'd4);
        i_step_done = 1'b1;
        wr(ADDR_CTRL, 32'd1);
        chk("run_visible", 32'(o_running), 1);
        wait_req(n);
        chk("first_req_latency", 32'(n), 5);
        for (int k = 1; k <= 3; k++) begin
            tick;
            chk("gen_count", 32'(o_generation), 32'(k));
            chk("req_drop", 32'(o_step_req), 0);
            if (k < 3) begin
                wait_req(n);
                chk("req_interval", 32'(n + 1), 5);
            end
        end
        i_step_done = 1'b0;
        wr(ADDR_CTRL, 32'd0);
        tick;
        chk("stop_idle", 32'(dut.r_state), 32'(IDLE));
        chk("stop_running", 32'(o_running), 0);
        wr(ADDR_CTRL, 32'd4);
        chk("clr_gen", 32'(o_generation), 0);

        // Loader busy across timer expiry parks the machine in HOLD.
        i_loader_busy = 1'b1;
        wr(ADDR_CTRL, 32'd1);
        repeat (5) tick;
        chk("hold_state", 32'(dut.r_state), 32'(HOLD));
        chk("hold_req_low", 32'(o_step_req), 0);
        hi = 0;
        repeat (9) begin
            tick;
            if (o_step_req) hi++;
        end
        chk("hold_no_req", 32'(hi), 0);
        chk("hold_still", 32'(dut.r_state), 32'(HOLD));
        i_loader_busy = 1'b0;
        tick;
        chk("req_after_busy", 32'(o_step_req), 1);
        i_loader_busy = 1'b1;
        repeat (3) tick;
        chk("req_holds_busy", 32'(o_step_req), 1);
        wr(ADDR_CTRL, 32'd0);
        chk("run_cleared_in_req", 32'(o_running), 0);
        chk("req_survives_run_clr", 32'(o_step_req), 1);
        i_step_done = 1'b1;
        tick;
        i_step_done   = 1'b0;
        i_loader_busy = 1'b0;
        chk("req_done_drop", 32'(o_step_req), 0);
        chk("gen_after_hold", 32'(o_generation), 1);
        chk("idle_after_clr_run", 32'(dut.r_state), 32'(IDLE));

        // Two back-to-back STEP writes launch exactly one step.
        wr(ADDR_CTRL, 32'd4);
        i_control_write = 1'b1;
        i_control_addr  = ADDR_CTRL;
        i_control_data  = 32'd2;
        tick;
        tick;
        i_control_write = 1'b0;
        i_control_data  = '0;
        chk("single_req", 32'(o_step_req), 1);
        tick;
        tick;
        i_step_done = 1'b1;
        tick;
        i_step_done = 1'b0;
        chk("single_gen", 32'(o_generation), 1);
        chk("single_req_drop", 32'(o_step_req), 0);
        hi = 0;
        repeat (6) begin
            tick;
            if (o_step_req) hi++;
        end
        chk("single_no_second", 32'(hi), 0);
        chk("single_gen_final", 32'(o_generation), 1);
        chk("single_idle", 32'(dut.r_state), 32'(IDLE));

        // Generation wrap at 4 bits and clear-vs-completion priority.
        i_step_done = 1'b1;
        for (int k = 0; k < 14; k++) begin
            wr(ADDR_CTRL, 32'd2);
            tick;
            tick;
        end
        chk("gen_max", 32'(o_generation), 15);
        wr(ADDR_CTRL, 32'd2);
        tick;
        tick;
        chk("gen_wrap", 32'(o_generation), 0);
        wr(ADDR_CTRL, 32'd2);
        tick;
        tick;
        chk("gen_after_wrap", 32'(o_generation), 1);
        wr(ADDR_CTRL, 32'd2);
        tick;
        chk("req_before_clr", 32'(o_step_req), 1);
        wr(ADDR_CTRL, 32'd4);
        chk("clr_wins", 32'(o_generation), 0);
        chk("clr_req_drop", 32'(o_step_req), 0);
        i_step_done = 1'b0;

        // Generation limit of 3 with PERIOD=1.
        wr(ADDR_GEN_LIMIT, 32'd3);
        wr(ADDR_PERIOD, 32'd1);
        i_step_done = 1'b1;
        wr(ADDR_CTRL, 32'd1);
        pulses = 0;
        repeat (20) begin
            tick;
            if (o_limit_hit) pulses++;
        end
`ifdef SILIFE_GEN_LIMIT_EN
        chk("limit_pulses", 32'(pulses), 1);
        chk("limit_running", 32'(o_running), 0);
        chk("limit_gen", 32'(o_generation), 3);
        chk("limit_idle", 32'(dut.r_state), 32'(IDLE));
`else
        chk("nolimit_pulses", 32'(pulses), 0);
        chk("nolimit_running", 32'(o_running), 1);
        chk("nolimit_gen", 32'(o_generation), 9);
`endif
        wr(ADDR_CTRL, 32'd0);
        i_step_done = 1'b0;
        repeat (3) tick;
        chk("limit_end_idle", 32'(dut.r_state), 32'(IDLE));

        // Asynchronous reset in the middle of a request.
        wr(ADDR_CTRL, 32'd2);
        tick;
        chk("req_before_rst", 32'(o_step_req), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_req_drop", 32'(o_step_req), 0);
        chk("async_gen", 32'(o_generation), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick;
        chk("post_rst_req", 32'(o_step_req), 0);
        chk("post_rst_running", 32'(o_running), 0);
        chk("post_rst_gen", 32'(o_generation), 0);
        chk("post_rst_limit", 32'(o_limit_hit), 0);
        chk("post_rst_state", 32'(dut.r_state), 32'(IDLE));
        chk("post_rst_period", 32'(dut.r_period), 1000000);

        // PERIOD=0 behaves as PERIOD=1.
        wr(ADDR_PERIOD, 32'd0);
        i_step_done = 1'b1;
        wr(ADDR_CTRL, 32'd1);
        wait_req(n);
        chk("p0_first_latency", 32'(n), 2);
        tick;
        wait_req(n);
        chk("p0_interval", 32'(n + 1), 2);
        i_step_done = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/silife_step_scheduler.md
# silife_step_scheduler

Generation scheduler for the SiLife grid. It decodes control-register writes arriving from the grid loader's control write strobe, address and data outputs. It paces grid evolution with a programmable step period and issues step requests to the grid with a request/done handshake. It never launches a step while the loader is driving cell data into the grid, and it maintains the generation counter.

## Interface
Parameters:
- PERIOD_BITS, 24, width of the step-period register and timer
- GEN_BITS, 32, width of the generation counter
- RESET_PERIOD, 24'd1000000, period register value after reset

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- i_control_write  in  1  one-cycle write strobe from the loader
- i_control_addr  in  24  register address, valid with strobe
- i_control_data  in  32  register data, valid with strobe
- i_loader_busy  in  1  loader selected and in cell-data phase
- i_step_done  in  1  grid finished the requested generation
- o_step_req  out  1  step request to grid, level until done
- o_running  out  1  RUN bit as currently held
- o_generation  out  GEN_BITS  completed generations
- o_limit_hit  out  1  one-cycle pulse on auto-stop

## Operation
Register map (writes to other addresses are ignored):
- 0x000000 CTRL: bit0 RUN (level); bit1 STEP (write-1 pulse, arms one single step); bit2 CLR_GEN (write-1 pulse, zeroes generation)
- 0x000001 PERIOD: data[PERIOD_BITS-1:0]; 0 behaves as 1
- 0x000002 GEN_LIMIT: only when the configuration macro is defined

State machine:
- IDLE: RUN=1 -> WAIT, timer loaded from PERIOD. Armed STEP -> HOLD if i_loader_busy, else STEP_REQ.
- WAIT: timer decrements each cycle. RUN cleared -> IDLE. Timer reaches 0 -> HOLD if busy, else STEP_REQ.
- HOLD: leaves to STEP_REQ on the first cycle i_loader_busy is low.
- STEP_REQ: o_step_req=1. When i_step_done=1, generation increments and the machine goes to WAIT with timer reload if RUN=1, otherwise to IDLE.

Rules:
- A STEP write while RUN=1 is discarded.
- A STEP write while a single step is already armed or in flight is discarded; only one step is ever pending.
- i_loader_busy is checked only at launch. Once o_step_req is high, the request holds until done, even if busy rises.
- Clearing RUN during STEP_REQ lets the step complete, then the machine goes to IDLE.
- Generation wraps modulo 2^GEN_BITS.
- CLR_GEN and step completion in the same cycle: clear wins, generation=0.
- PERIOD written during WAIT applies at the next reload only.
- i_step_done outside STEP_REQ is ignored.

## Timing
- Reset values: state IDLE, o_step_req=0, o_running=0, o_generation=0, o_limit_hit=0, PERIOD=RESET_PERIOD, GEN_LIMIT=0.
- A control write is visible in the registers and o_running on the cycle after the strobe.
- Running with PERIOD=P and zero-latency done: successive o_step_req rising edges are exactly P+1 clocks apart (P WAIT cycles plus 1 STEP_REQ cycle).
- o_step_req is registered and drops on the cycle after i_step_done is sampled high. o_generation updates on that same edge.
- Assertion of reset_n low mid-step drops o_step_req immediately and asynchronously.

## Configuration
- SILIFE_GEN_LIMIT_EN defined:
  - GEN_LIMIT register is present.
  - When GEN_LIMIT≠0 and the incremented generation equals GEN_LIMIT, RUN clears, the machine goes to IDLE and o_limit_hit pulses for one cycle.
  - A simultaneous CLR_GEN suppresses the compare.
- SILIFE_GEN_LIMIT_EN undefined: address 0x000002 is ignored, o_limit_hit is tied 0, no compare logic is built.

## Structure
- Package silife_sched_pkg: register address localparams (CTRL, PERIOD, GEN_LIMIT), CTRL bit indices, state enum (IDLE, WAIT, HOLD, STEP_REQ).
- Sub-module silife_step_timer: loadable PERIOD_BITS down-counter with load, enable and zero flag; maps 0 to 1.
- Register decode, FSM and generation counter live in the top module.

## Test plan
- Reset, write PERIOD=4, CTRL=1, done tied high -> o_step_req rises every 5 clocks; o_generation counts 1,2,3.
- i_loader_busy held high across timer expiry for 10 cycles -> state HOLD, no o_step_req; busy falls -> o_step_req on the next cycle.
- RUN=0, write CTRL=2 twice back-to-back, done after 3 cycles -> exactly one step, generation=1, final state IDLE.
- Generation preset to 2^GEN_BITS−1 via repeated steps with GEN_BITS=4 -> next completion yields 0; CLR_GEN coincident with done -> 0.
- With SILIFE_GEN_LIMIT_EN, GEN_LIMIT=3, RUN=1 -> after generation 3, o_limit_hit pulses once and o_running=0; without the macro, write is ignored and running continues.
- Assert reset_n low while o_step_req=1 -> o_step_req=0 asynchronously; after release all outputs are at their reset values.
